// File: rtl/mgr_noc_dp_arbiter.sv
// Round-robin, packet-locked arbiter sharing the manager's single NoC dp send port among NUM_REQ requesters.
// Define MGR_NOC_DP_ARB_STATS_EN to add per-requester saturating packet counters (arb__sys__pkt_count).
module mgr_noc_dp_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64,
   parameter int TYPE_W  = 2,
   parameter int CNTL_W  = 2,
   parameter int PEID_W  = 8,
   parameter int LANE_W  = 5,
   parameter int STRM_W  = 2
) (
   input  logic                        clk,
   input  logic                        reset_poweron,
   // A beat moves on a side when valid & ready are both high at a rising clk edge; valid never waits on ready.
   input  logic [NUM_REQ-1:0]          req__arb__valid,
   output logic [NUM_REQ-1:0]          arb__req__ready,
   input  logic [NUM_REQ*CNTL_W-1:0]   req__arb__cntl,
   input  logic [NUM_REQ*TYPE_W-1:0]   req__arb__type,
   input  logic [NUM_REQ*PEID_W-1:0]   req__arb__peId,
   input  logic [NUM_REQ*LANE_W-1:0]   req__arb__laneId,
   input  logic [NUM_REQ*STRM_W-1:0]   req__arb__strmId,
   input  logic [NUM_REQ*DATA_W-1:0]   req__arb__data,
   output logic                        arb__noc__dp_valid,
   input  logic                        noc__arb__dp_ready,
   output logic [CNTL_W-1:0]           arb__noc__dp_cntl,
   output logic [TYPE_W-1:0]           arb__noc__dp_type,
   output logic [PEID_W-1:0]           arb__noc__dp_peId,
   output logic [LANE_W-1:0]           arb__noc__dp_laneId,
   output logic [STRM_W-1:0]           arb__noc__dp_strmId,
   output logic [DATA_W-1:0]           arb__noc__dp_data,
   output logic [2:0]                  arb__sys__owner,
   output logic                        arb__sys__proto_err,
`ifdef MGR_NOC_DP_ARB_STATS_EN
   output logic [NUM_REQ*16-1:0]       arb__sys__pkt_count,
`endif
   output logic                        o_dbg_state,
   output logic [2:0]                  o_dbg_rr
);

   typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_owner, w_owner_nxt;
   logic [2:0]          r_rr, w_rr_nxt;
   logic                r_dp_valid;
   logic [CNTL_W-1:0]   r_cntl;
   logic [TYPE_W-1:0]   r_type;
   logic [PEID_W-1:0]   r_peid;
   logic [LANE_W-1:0]   r_lane;
   logic [STRM_W-1:0]   r_strm;
   logic [DATA_W-1:0]   r_data;
   logic                r_err;

   logic                w_load, w_gnt_vld, w_accept, w_err;
   logic [2:0]          w_sel;
   int                  w_dist, w_best;
   logic [CNTL_W-1:0]   w_sel_cntl;
   logic [TYPE_W-1:0]   w_sel_type;
   logic [PEID_W-1:0]   w_sel_peid;
   logic [LANE_W-1:0]   w_sel_lane;
   logic [STRM_W-1:0]   w_sel_strm;
   logic [DATA_W-1:0]   w_sel_data;

   // cntl bit 0 marks a start (SOM/SOM_EOM), bit 1 marks an end (EOM/SOM_EOM).
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr;
      w_sel       = r_owner;
      w_gnt_vld   = 1'b0;
      w_err       = 1'b0;
      w_dist      = 0;
      w_best      = NUM_REQ;
      w_load      = !r_dp_valid || noc__arb__dp_ready;
      if (r_state == ST_ARB) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_rr);
            if (w_dist < 0) w_dist = w_dist + NUM_REQ;
            if (req__arb__valid[i] && req__arb__cntl[i*CNTL_W] && (w_dist < w_best)) begin
               w_best    = w_dist;
               w_sel     = 3'(i);
               w_gnt_vld = 1'b1;
            end
            if (req__arb__valid[i] && !req__arb__cntl[i*CNTL_W]) w_err = 1'b1;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == r_owner) w_gnt_vld = req__arb__valid[i];
         end
      end
      w_accept = w_gnt_vld && w_load;

      w_sel_cntl = '0;
      w_sel_type = '0;
      w_sel_peid = '0;
      w_sel_lane = '0;
      w_sel_strm = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == w_sel) begin
            w_sel_cntl = req__arb__cntl[i*CNTL_W +: CNTL_W];
            w_sel_type = req__arb__type[i*TYPE_W +: TYPE_W];
            w_sel_peid = req__arb__peId[i*PEID_W +: PEID_W];
            w_sel_lane = req__arb__laneId[i*LANE_W +: LANE_W];
            w_sel_strm = req__arb__strmId[i*STRM_W +: STRM_W];
            w_sel_data = req__arb__data[i*DATA_W +: DATA_W];
         end
      end

      if (w_accept) begin
         if (r_state == ST_ARB) begin
            w_rr_nxt = (int'(w_sel) == NUM_REQ - 1) ? 3'd0 : w_sel + 3'd1;
            if (!w_sel_cntl[1]) begin
               w_state_nxt = ST_LOCK;
               w_owner_nxt = w_sel;
            end
         end else begin
            // A start marker inside a packet is flagged but still forwarded; SOM_EOM closes it like EOM.
            if (w_sel_cntl[0]) w_err = 1'b1;
            if (w_sel_cntl[1]) w_state_nxt = ST_ARB;
         end
      end

      arb__req__ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb__req__ready[i] = w_accept && (3'(i) == w_sel);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         r_state <= ST_ARB;
         r_owner <= '0;
         r_rr    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         r_dp_valid <= 1'b0;
         r_cntl     <= '0;
         r_type     <= '0;
         r_peid     <= '0;
         r_lane     <= '0;
         r_strm     <= '0;
         r_data     <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_err;
         if (w_accept) begin
            r_dp_valid <= 1'b1;
            r_cntl     <= w_sel_cntl;
            r_type     <= w_sel_type;
            r_peid     <= w_sel_peid;
            r_lane     <= w_sel_lane;
            r_strm     <= w_sel_strm;
            r_data     <= w_sel_data;
         end else if (noc__arb__dp_ready) begin
            r_dp_valid <= 1'b0;
         end
      end
   end

`ifdef MGR_NOC_DP_ARB_STATS_EN
   logic [15:0] r_pkt_cnt [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset_poweron) begin
            r_pkt_cnt[i] <= '0;
         end else if (w_accept && w_sel_cntl[1] && (3'(i) == w_sel) && (r_pkt_cnt[i] != 16'hFFFF)) begin
            r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
         end
      end
   end

   always_comb begin
      arb__sys__pkt_count = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb__sys__pkt_count[i*16 +: 16] = r_pkt_cnt[i];
      end
   end
`endif

   assign arb__noc__dp_valid  = r_dp_valid;
   assign arb__noc__dp_cntl   = r_cntl;
   assign arb__noc__dp_type   = r_type;
   assign arb__noc__dp_peId   = r_peid;
   assign arb__noc__dp_laneId = r_lane;
   assign arb__noc__dp_strmId = r_strm;
   assign arb__noc__dp_data   = r_data;
   assign arb__sys__owner     = r_owner;
   assign arb__sys__proto_err = r_err;
   assign o_dbg_state         = r_state;
   assign o_dbg_rr            = r_rr;

endmodule

// File: tb/tb_mgr_noc_dp_arbiter.sv
// Self-checking bench for mgr_noc_dp_arbiter: queue-driven requesters, packet-level reference model, output scoreboard.
`timescale 1ns/1ps
module tb_mgr_noc_dp_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 64;
   localparam int TYPE_W  = 2;
   localparam int CNTL_W  = 2;
   localparam int PEID_W  = 8;
   localparam int LANE_W  = 5;
   localparam int STRM_W  = 2;
   localparam int O_STRM  = DATA_W;
   localparam int O_LANE  = O_STRM + STRM_W;
   localparam int O_PEID  = O_LANE + LANE_W;
   localparam int O_TYPE  = O_PEID + PEID_W;
   localparam int O_CNTL  = O_TYPE + TYPE_W;
   localparam int BEAT_W  = O_CNTL + CNTL_W;
   localparam logic [1:0] C_SOM = 2'b01, C_MOM = 2'b00, C_EOM = 2'b10, C_SE = 2'b11;

   logic                       clk = 1'b0;
   logic                       reset_poweron;
   logic [NUM_REQ-1:0]         req_valid, req_ready;
   logic [NUM_REQ*CNTL_W-1:0]  req_cntl;
   logic [NUM_REQ*TYPE_W-1:0]  req_type;
   logic [NUM_REQ*PEID_W-1:0]  req_peid;
   logic [NUM_REQ*LANE_W-1:0]  req_lane;
   logic [NUM_REQ*STRM_W-1:0]  req_strm;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic                       dp_valid, dp_ready;
   logic [CNTL_W-1:0]          dp_cntl;
   logic [TYPE_W-1:0]          dp_type;
   logic [PEID_W-1:0]          dp_peid;
   logic [LANE_W-1:0]          dp_lane;
   logic [STRM_W-1:0]          dp_strm;
   logic [DATA_W-1:0]          dp_data;
   logic [2:0]                 owner;
   logic                       proto_err;
   logic                       dbg_state;
   logic [2:0]                 dbg_rr;
`ifdef MGR_NOC_DP_ARB_STATS_EN
   logic [NUM_REQ*16-1:0]      pkt_count;
`endif

   always #5 clk = ~clk;

   mgr_noc_dp_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .CNTL_W(CNTL_W),
      .PEID_W(PEID_W), .LANE_W(LANE_W), .STRM_W(STRM_W)
   ) dut (
      .clk                 (clk),
      .reset_poweron       (reset_poweron),
      .req__arb__valid     (req_valid),
      .arb__req__ready     (req_ready),
      .req__arb__cntl      (req_cntl),
      .req__arb__type      (req_type),
      .req__arb__peId      (req_peid),
      .req__arb__laneId    (req_lane),
      .req__arb__strmId    (req_strm),
      .req__arb__data      (req_data),
      .arb__noc__dp_valid  (dp_valid),
      .noc__arb__dp_ready  (dp_ready),
      .arb__noc__dp_cntl   (dp_cntl),
      .arb__noc__dp_type   (dp_type),
      .arb__noc__dp_peId   (dp_peid),
      .arb__noc__dp_laneId (dp_lane),
      .arb__noc__dp_strmId (dp_strm),
      .arb__noc__dp_data   (dp_data),
      .arb__sys__owner     (owner),
      .arb__sys__proto_err (proto_err),
`ifdef MGR_NOC_DP_ARB_STATS_EN
      .arb__sys__pkt_count (pkt_count),
`endif
      .o_dbg_state         (dbg_state),
      .o_dbg_rr            (dbg_rr)
   );

   int total = 0;
   int bad   = 0;
   logic [BEAT_W-1:0] src_q [NUM_REQ][$];
   logic [BEAT_W-1:0] exp_q[$];
   int valid_pct [NUM_REQ];
   int ready_mode;
   int cyc;
   int grant_log[$];
   int out_src_log[$];
   int err_seen;
   int beats_pushed;

   // Reference model: lock owner (-1 = arbitrating), rr pointer, one-deep output slot.
   int                m_lock;
   int                m_rr;
   bit                m_out_valid;
   logic [BEAT_W-1:0] m_out;
   bit                m_err;
   int                m_cnt [NUM_REQ];

   function automatic logic [BEAT_W-1:0] mk_beat(int r, logic [1:0] c, int seq);
      logic [DATA_W-1:0] d;
      d = {$urandom, $urandom};
      d[63:60] = 4'(r);
      d[59:52] = 8'(seq);
      return {c, 2'($urandom), 8'($urandom), 5'($urandom), 2'($urandom), d};
   endfunction

   task automatic add_pkt(int r, int len);
      logic [1:0] c;
      for (int b = 0; b < len; b++) begin
         if (len == 1)          c = C_SE;
         else if (b == 0)       c = C_SOM;
         else if (b == len - 1) c = C_EOM;
         else                   c = C_MOM;
         src_q[r].push_back(mk_beat(r, c, b));
         beats_pushed++;
      end
   endtask

   task automatic model_reset();
      m_lock = -1;
      m_rr = 0;
      m_out_valid = 1'b0;
      m_out = '0;
      m_err = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
   endtask

   task automatic clear_bench();
      for (int r = 0; r < NUM_REQ; r++) begin
         src_q[r].delete();
         valid_pct[r] = 100;
      end
      exp_q.delete();
      grant_log.delete();
      out_src_log.delete();
      err_seen = 0;
      beats_pushed = 0;
      cyc = 0;
      ready_mode = 0;
   endtask

   task automatic drive_inputs();
      logic [BEAT_W-1:0] b;
      cyc++;
      for (int r = 0; r < NUM_REQ; r++) begin
         b = '0;
         req_valid[r] = 1'b0;
         if (src_q[r].size() > 0 && $urandom_range(1, 100) <= valid_pct[r]) begin
            b = src_q[r][0];
            req_valid[r] = 1'b1;
         end
         req_cntl[r*CNTL_W +: CNTL_W] = b[O_CNTL +: CNTL_W];
         req_type[r*TYPE_W +: TYPE_W] = b[O_TYPE +: TYPE_W];
         req_peid[r*PEID_W +: PEID_W] = b[O_PEID +: PEID_W];
         req_lane[r*LANE_W +: LANE_W] = b[O_LANE +: LANE_W];
         req_strm[r*STRM_W +: STRM_W] = b[O_STRM +: STRM_W];
         req_data[r*DATA_W +: DATA_W] = b[0 +: DATA_W];
      end
      case (ready_mode)
         0:       dp_ready = 1'b1;
         1:       dp_ready = 1'($urandom_range(0, 1));
         default: dp_ready = ((cyc % 3) == 1);
      endcase
   endtask

   // One clock: drive at negedge, check just before posedge, advance model at posedge.
   task automatic step();
      int g;
      bit can_load, err_now, is_start;
      logic [NUM_REQ-1:0] exp_rdy, rdy_s;
      logic [BEAT_W-1:0] b, dut_b;
      drive_inputs();
      #1;
      can_load = !m_out_valid || dp_ready;
      g = -1;
      err_now = 1'b0;
      if (m_lock >= 0) begin
         if (req_valid[m_lock]) g = m_lock;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_rr + k) % NUM_REQ;
            if (g < 0 && req_valid[idx]) begin
               b = src_q[idx][0];
               if (b[O_CNTL]) g = idx;
            end
         end
         for (int r = 0; r < NUM_REQ; r++) begin
            if (req_valid[r]) begin
               b = src_q[r][0];
               if (!b[O_CNTL]) err_now = 1'b1;
            end
         end
      end
      exp_rdy = '0;
      if (g >= 0 && can_load) begin
         exp_rdy[g] = 1'b1;
         b = src_q[g][0];
         is_start = b[O_CNTL];
         if (m_lock >= 0 && is_start) err_now = 1'b1;
      end
      rdy_s = req_ready;
      dut_b = {dp_cntl, dp_type, dp_peid, dp_lane, dp_strm, dp_data};

      total++;
      if (req_ready !== exp_rdy) begin
         bad++;
         $display("FAIL ready cyc=%0d: got %b want %b", cyc, req_ready, exp_rdy);
      end
      total++;
      if (dp_valid !== m_out_valid) begin
         bad++;
         $display("FAIL dp_valid cyc=%0d: got %b want %b", cyc, dp_valid, m_out_valid);
      end
      if (m_out_valid) begin
         total++;
         if (dut_b !== m_out) begin
            bad++;
            $display("FAIL dp_beat cyc=%0d: got %h want %h", cyc, dut_b, m_out);
         end
      end
      total++;
      if (proto_err !== m_err) begin
         bad++;
         $display("FAIL proto_err cyc=%0d: got %b want %b", cyc, proto_err, m_err);
      end
      total++;
      if (dbg_state !== 1'(m_lock >= 0) || dbg_rr !== 3'(m_rr)) begin
         bad++;
         $display("FAIL state_rr cyc=%0d: got lock=%b rr=%0d want lock=%b rr=%0d",
                  cyc, dbg_state, dbg_rr, (m_lock >= 0), m_rr);
      end
      if (m_lock >= 0) begin
         total++;
         if (owner !== 3'(m_lock)) begin
            bad++;
            $display("FAIL owner cyc=%0d: got %0d want %0d", cyc, owner, m_lock);
         end
      end
      if (proto_err === 1'b1) err_seen++;
      if (dp_valid === 1'b1 && dp_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra cyc=%0d: got beat %h want none", cyc, dut_b);
         end else begin
            b = exp_q.pop_front();
            if (dut_b !== b) begin
               bad++;
               $display("FAIL sb_order cyc=%0d: got %h want %h", cyc, dut_b, b);
            end
            out_src_log.push_back(int'(dut_b[63:60]));
         end
      end

      @(posedge clk);
      if (g >= 0 && can_load) begin
         b = src_q[g][0];
         exp_q.push_back(b);
         m_out = b;
         m_out_valid = 1'b1;
         if (m_lock < 0) begin
            grant_log.push_back(g);
            m_rr = (g + 1) % NUM_REQ;
            if (!b[O_CNTL+1]) m_lock = g;
         end else if (b[O_CNTL+1]) begin
            m_lock = -1;
         end
         if (b[O_CNTL+1] && m_cnt[g] < 65535) m_cnt[g]++;
      end else if (dp_ready) begin
         m_out_valid = 1'b0;
      end
      m_err = err_now;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (rdy_s[r] && req_valid[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_poweron = 1'b1;
      req_valid = '0;
      req_cntl = '0;
      req_type = '0;
      req_peid = '0;
      req_lane = '0;
      req_strm = '0;
      req_data = '0;
      dp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_poweron = 1'b0;
      model_reset();
      clear_bench();
   endtask

   task automatic drain(string name, int limit);
      int n;
      bit busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < limit) begin
         busy = (exp_q.size() > 0) || m_out_valid;
         for (int r = 0; r < NUM_REQ; r++) if (src_q[r].size() > 0) busy = 1'b1;
         if (busy) begin
            step();
            n++;
         end
      end
      total++;
      if (busy) begin
         bad++;
         $display("FAIL %s_drain: got busy after %0d cycles want idle", name, n);
      end
      total++;
      if (out_src_log.size() != beats_pushed) begin
         bad++;
         $display("FAIL %s_beats: got %0d delivered want %0d", name, out_src_log.size(), beats_pushed);
      end
   endtask

   task automatic check_log(string name, int got[$], int want[$]);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %p want %p", name, got, want);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({dp_valid, dp_cntl, dp_type, dp_peid, dp_lane, dp_strm, dp_data, owner, proto_err, req_ready} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b data=%h owner=%0d err=%b ready=%b want all 0",
                  dp_valid, dp_data, owner, proto_err, req_ready);
      end
`ifdef MGR_NOC_DP_ARB_STATS_EN
      total++;
      if (pkt_count !== '0) begin
         bad++;
         $display("FAIL reset_counts: got %h want 0", pkt_count);
      end
`endif
      repeat (10) step();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int r = 0; r < NUM_REQ; r++) add_pkt(r, 3);
      drain("rr", 200);
      check_log("rr_grants", grant_log, '{0, 1, 2, 3});
      check_log("rr_beats", out_src_log, '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3});
   endtask

   task automatic test_backpressure();
      do_reset();
      ready_mode = 2;
      add_pkt(1, 4);
      add_pkt(2, 3);
      drain("bp", 300);
      check_log("bp_grants", grant_log, '{1, 2});
      check_log("bp_beats", out_src_log, '{1, 1, 1, 1, 2, 2, 2});
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         add_pkt(0, 1);
         add_pkt(3, 1);
      end
      drain("b2b", 200);
      check_log("b2b_grants", grant_log, '{0, 3, 0, 3, 0, 3, 0, 3, 0, 3, 0, 3});
   endtask

   task automatic test_proto_err();
      do_reset();
      src_q[2].push_back(mk_beat(2, C_MOM, 0));
      src_q[0].push_back(mk_beat(0, C_SOM, 0));
      src_q[0].push_back(mk_beat(0, C_SE, 1));
      src_q[1].push_back(mk_beat(1, C_SOM, 0));
      src_q[1].push_back(mk_beat(1, C_SOM, 1));
      src_q[1].push_back(mk_beat(1, C_EOM, 2));
      beats_pushed = 5;
      repeat (12) step();
      src_q[2].delete();
      drain("perr", 100);
      check_log("perr_grants", grant_log, '{0, 1});
      total++;
      if (err_seen < 10) begin
         bad++;
         $display("FAIL perr_pulses: got %0d want >= 10", err_seen);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      add_pkt(0, 4);
      step();
      step();
      drive_inputs();
      reset_poweron = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (dp_valid !== 1'b0 || dbg_state !== 1'b0 || dbg_rr !== 3'd0 || proto_err !== 1'b0) begin
         bad++;
         $display("FAIL midrst_state: got valid=%b lock=%b rr=%0d err=%b want 0 0 0 0",
                  dp_valid, dbg_state, dbg_rr, proto_err);
      end
      @(negedge clk);
      reset_poweron = 1'b0;
      model_reset();
      clear_bench();
`ifdef MGR_NOC_DP_ARB_STATS_EN
      total++;
      if (pkt_count !== '0) begin
         bad++;
         $display("FAIL midrst_counts0: got %h want 0", pkt_count);
      end
`endif
      add_pkt(0, 2);
      add_pkt(0, 2);
      drain("midrst", 100);
      check_log("midrst_grants", grant_log, '{0, 0});
`ifdef MGR_NOC_DP_ARB_STATS_EN
      total++;
      if (pkt_count !== {16'd0, 16'd0, 16'd0, 16'd2}) begin
         bad++;
         $display("FAIL midrst_counts2: got %h want %h", pkt_count, {16'd0, 16'd0, 16'd0, 16'd2});
      end
`endif
   endtask

   task automatic test_random();
      do_reset();
      ready_mode = 1;
      for (int r = 0; r < NUM_REQ; r++) valid_pct[r] = $urandom_range(60, 100);
      for (int p = 0; p < 30; p++) add_pkt($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 4));
      drain("rand", 3000);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_backpressure();
      test_back_to_back();
      test_proto_err();
      test_reset_mid_packet();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
